seq_gen: RTL and testbench
==========================

SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the repeat count and pattern counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to emit a burst; sampled only in IDLE.
REQ-005 SHALL have port rep  input  CNT_W  number of 01-10-11 patterns in the burst; latched on an accepted start.
REQ-006 SHALL have port hold  input  2  extra 11 cycles appended to each pattern; latched on an accepted start.
REQ-007 SHALL have port num  output  2  symbol stream toward the counting detector; 00 when not emitting.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until return to IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse at normal burst completion.
REQ-010 SHALL have port pat_cnt  output  CNT_W  number of patterns emitted in the current or last burst.

Function
REQ-011 SHALL drive all outputs from registers; no combinational path from any input to any output.
REQ-012 SHALL implement states IDLE, E1, E2, E3, HOLD, GAP, FIN.
REQ-013 SHALL accept start only when in IDLE; start while busy SHALL be ignored with no side effect.
REQ-014 Accepted start with rep!=0 SHALL latch rep and hold, clear pat_cnt, and enter E1 on the next edge.
REQ-015 Accepted start with rep==0 SHALL enter FIN directly; no nonzero symbol emitted, pat_cnt=0.
REQ-016 Per-state num: E1=01, E2=10, E3=11, HOLD=11, GAP=00, FIN=00, IDLE=00.
REQ-017 Transitions: E1->E2->E3 unconditionally, one cycle each.
REQ-018 From E3: hold!=0 -> HOLD; else if patterns remain -> GAP; else -> FIN.
REQ-019 HOLD SHALL last exactly hold cycles, then go to GAP if patterns remain, else FIN.
REQ-020 GAP SHALL last exactly one cycle, then E1.
REQ-021 FIN SHALL last one cycle with done=1, then IDLE; done SHALL be 0 in all other states.
REQ-022 pat_cnt SHALL increment by 1 in the cycle E3 is entered; no wrap possible since pat_cnt<=rep.
REQ-023 pat_cnt SHALL hold its value in IDLE until the next accepted start.
REQ-024 busy SHALL be 1 in E1, E2, E3, HOLD, GAP, and FIN; 0 in IDLE.
REQ-025 Burst length in cycles SHALL equal rep*(3+hold)+(rep-1)+1 for rep>=1, the final +1 being FIN.
REQ-026 Each emitted pattern SHALL cause exactly 1+hold ans assertions in a connected counting detector.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, num=00, busy=0, done=0, and pat_cnt=0, and clear the latched rep and hold.
REQ-028 Reset mid-burst SHALL abandon the burst without a done pulse; the first accepted start after release SHALL begin a fresh burst.

Configuration
REQ-029 Macro SEQ_GEN_ABORT_EN, when defined, SHALL add port abort  input  1.
REQ-030 With SEQ_GEN_ABORT_EN: abort=1 sampled in any busy state except FIN SHALL go to IDLE on that edge.
REQ-031 With SEQ_GEN_ABORT_EN, on abort: num=00 the next cycle, no done pulse, pat_cnt held.
REQ-032 With SEQ_GEN_ABORT_EN: abort in IDLE or FIN SHALL be ignored; abort and start together in IDLE SHALL accept start.
REQ-033 Without SEQ_GEN_ABORT_EN, the abort port SHALL be absent and bursts SHALL run to completion.

Verification
REQ-034 rep=1, hold=0, start pulse -> num 01,10,11,00; done at cycle 4 after start; pat_cnt=1; detector ans once.
REQ-035 rep=2, hold=2 -> num 01,10,11,11,11,00,01,10,11,11,11,00 with done on the final 00; pat_cnt=2; ans 6 times.
REQ-036 rep=0, start -> busy for 1 cycle, done next cycle, num stays 00, pat_cnt=0.
REQ-037 rep=3 with start re-pulsed mid-burst -> no disturbance; exactly 3 patterns, single done.
REQ-038 rst_n low during HOLD of rep=2 -> num=00 and busy=0 immediately, no done; next start runs the full burst.
REQ-039 SEQ_GEN_ABORT_EN, abort during E2 of pattern 2 -> IDLE, num=00 next cycle, pat_cnt=1, no done.

Source files
------------

// File: rtl/seq_gen.sv
// seq_gen: burst generator emitting repeated 01-10-11 symbol patterns on num,
// each followed by an optional run of extra 11 symbols (hold) and a 00 gap
// between patterns. The burst ends in a one-cycle FIN state with done=1.
//
// Optional feature macro: SEQ_GEN_ABORT_EN
//   When defined, an 'abort' input is added. Sampled high in E1/E2/E3/HOLD/GAP
//   it drops the burst back to IDLE with no done pulse and pat_cnt held.
//   Without the macro the port is absent and bursts always run to completion.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; num=00, busy=0
// E1    | first symbol of a pattern, num=01
// E2    | second symbol of a pattern, num=10
// E3    | third symbol of a pattern, num=11; pat_cnt counts on entry
// HOLD  | extra 11 symbols, hold cycles long
// GAP   | single 00 separator between patterns
// FIN   | burst complete, done=1 for this one cycle, num=00
module seq_gen #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] rep,
  input  logic [1:0]       hold,
  output logic [1:0]       num,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pat_cnt
`ifdef SEQ_GEN_ABORT_EN
  ,
  input  logic             abort
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E1   = 3'd1,
    E2   = 3'd2,
    E3   = 3'd3,
    HOLD = 3'd4,
    GAP  = 3'd5,
    FIN  = 3'd6
  } state_t;

  localparam logic [1:0] SYM_00 = 2'b00;
  localparam logic [1:0] SYM_01 = 2'b01;
  localparam logic [1:0] SYM_10 = 2'b10;
  localparam logic [1:0] SYM_11 = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] rep_q;
  logic [1:0]       hold_q;
  logic [1:0]       hold_cnt;
  logic             abort_req;
  logic             in_burst;
  logic             more_pats;

  // abort request source; tied off when the abort feature is not built
`ifdef SEQ_GEN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // abort only acts in the emitting states; IDLE and FIN ignore it
  assign in_burst = (state == E1) || (state == E2) || (state == E3) ||
                    (state == HOLD) || (state == GAP);

  // pat_cnt already includes the pattern currently in E3/HOLD
  assign more_pats = (pat_cnt != rep_q);

  // sequencer: state, latched config, hold timer and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rep_q    <= '0;
      hold_q   <= '0;
      hold_cnt <= '0;
      num      <= SYM_00;
      busy     <= 1'b0;
      done     <= 1'b0;
      pat_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (abort_req && in_burst) begin
        state <= IDLE;
        num   <= SYM_00;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              rep_q   <= rep;
              hold_q  <= hold;
              pat_cnt <= '0;
              busy    <= 1'b1;
              if (rep == '0) begin
                // empty burst goes straight to completion, no symbols
                state <= FIN;
                num   <= SYM_00;
                done  <= 1'b1;
              end else begin
                state <= E1;
                num   <= SYM_01;
              end
            end
          end
          E1: begin
            state <= E2;
            num   <= SYM_10;
          end
          E2: begin
            state   <= E3;
            num     <= SYM_11;
            pat_cnt <= pat_cnt + CNT_W'(1);
          end
          E3: begin
            if (hold_q != 2'd0) begin
              // timer counts down to zero; last HOLD cycle sees zero
              state    <= HOLD;
              num      <= SYM_11;
              hold_cnt <= hold_q - 2'd1;
            end else if (more_pats) begin
              state <= GAP;
              num   <= SYM_00;
            end else begin
              state <= FIN;
              num   <= SYM_00;
              done  <= 1'b1;
            end
          end
          HOLD: begin
            if (hold_cnt != 2'd0) begin
              hold_cnt <= hold_cnt - 2'd1;
              num      <= SYM_11;
            end else if (more_pats) begin
              state <= GAP;
              num   <= SYM_00;
            end else begin
              state <= FIN;
              num   <= SYM_00;
              done  <= 1'b1;
            end
          end
          GAP: begin
            state <= E1;
            num   <= SYM_01;
          end
          FIN: begin
            state <= IDLE;
            num   <= SYM_00;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            num   <= SYM_00;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Testbench for seq_gen: a reference model expands (rep, hold) into the
// expected per-cycle num/busy/done/pat_cnt trace, pushed to a queue when the
// start pulse is driven and popped one entry per cycle as the DUT runs.
module tb_seq_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] rep;
  logic [1:0] hold;
  logic [1:0] num;
  logic       busy;
  logic       done;
  logic [3:0] pat_cnt;
`ifdef SEQ_GEN_ABORT_EN
  logic       abort;
`endif

  typedef struct packed {
    logic [1:0] num;
    logic       busy;
    logic       done;
    logic [3:0] pc;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  seq_gen #(.CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rep     (rep),
    .hold    (hold),
    .num     (num),
    .busy    (busy),
    .done    (done),
    .pat_cnt (pat_cnt)
`ifdef SEQ_GEN_ABORT_EN
    ,
    .abort   (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected trace of one burst; first entry is the cycle after start
  task automatic push_burst(input int r, input int h);
    if (r == 0) begin
      q.push_back('{num: 2'd0, busy: 1'b1, done: 1'b1, pc: 4'd0});
    end else begin
      for (int p = 1; p <= r; p++) begin
        q.push_back('{num: 2'd1, busy: 1'b1, done: 1'b0, pc: 4'(p - 1)});
        q.push_back('{num: 2'd2, busy: 1'b1, done: 1'b0, pc: 4'(p - 1)});
        for (int k = 0; k <= h; k++)
          q.push_back('{num: 2'd3, busy: 1'b1, done: 1'b0, pc: 4'(p)});
        if (p < r)
          q.push_back('{num: 2'd0, busy: 1'b1, done: 1'b0, pc: 4'(p)});
      end
      q.push_back('{num: 2'd0, busy: 1'b1, done: 1'b1, pc: 4'(r)});
    end
  endtask

  // called at a negedge in IDLE; returns at the negedge of the first burst cycle
  task automatic kick(input int r, input int h);
    start = 1'b1;
    rep   = 4'(r);
    hold  = 2'(h);
    push_burst(r, h);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    rep   = 4'd5;
    hold  = 2'd3;
    repeat (2) @(negedge clk);
    compared++;
    if (num !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || pat_cnt !== 4'd0) begin
      mismatched++;
      $display("FAIL reset: num=%0d busy=%0b done=%0b pat_cnt=%0d, want 0/0/0/0",
               num, busy, done, pat_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (num !== 2'd0 || busy !== 1'b0 || pat_cnt !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_release: num=%0d busy=%0b pat_cnt=%0d, want 0/0/0",
               num, busy, pat_cnt);
    end
  endtask

  // generic burst: check every cycle, count 11 symbols, check IDLE afterwards
  task automatic test_burst(input string name, input int r, input int h);
    exp_t e;
    int   ans = 0;
    int   cyc = 0;
    kick(r, h);
    while (q.size() > 0) begin
      e = q.pop_front();
      compared++;
      if (num !== e.num || busy !== e.busy || done !== e.done || pat_cnt !== e.pc) begin
        mismatched++;
        $display("FAIL %s cyc%0d: num=%0d busy=%0b done=%0b pat_cnt=%0d, want %0d/%0b/%0b/%0d",
                 name, cyc, num, busy, done, pat_cnt, e.num, e.busy, e.done, e.pc);
      end
      if (num === 2'd3) ans++;
      cyc++;
      @(negedge clk);
    end
    compared++;
    if (ans != r * (1 + h)) begin
      mismatched++;
      $display("FAIL %s ans: got %0d, want %0d", name, ans, r * (1 + h));
    end
    compared++;
    if (num !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || pat_cnt !== 4'(r)) begin
      mismatched++;
      $display("FAIL %s idle: num=%0d busy=%0b done=%0b pat_cnt=%0d, want 0/0/0/%0d",
               name, num, busy, done, pat_cnt, r);
    end
  endtask

  // start re-pulsed (with a different rep) mid-burst must be ignored
  task automatic test_restart;
    exp_t e;
    int   cyc = 0;
    int   dones = 0;
    kick(3, 1);
    while (q.size() > 0) begin
      e = q.pop_front();
      compared++;
      if (num !== e.num || busy !== e.busy || done !== e.done || pat_cnt !== e.pc) begin
        mismatched++;
        $display("FAIL restart cyc%0d: num=%0d busy=%0b done=%0b pat_cnt=%0d, want %0d/%0b/%0b/%0d",
                 cyc, num, busy, done, pat_cnt, e.num, e.busy, e.done, e.pc);
      end
      if (done === 1'b1) dones++;
      if (cyc == 4) begin start = 1'b1; rep = 4'd7; hold = 2'd0; end
      if (cyc == 6) start = 1'b0;
      cyc++;
      @(negedge clk);
    end
    compared++;
    if (dones != 1 || pat_cnt !== 4'd3 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL restart end: dones=%0d pat_cnt=%0d busy=%0b, want 1/3/0",
               dones, pat_cnt, busy);
    end
  endtask

  task automatic test_back_to_back;
    test_burst("b2b_a", 1, 3);
    test_burst("b2b_b", 4, 0);
    test_burst("b2b_c", 15, 0);
  endtask

  // reset during HOLD of a rep=2 burst, then a fresh full burst
  task automatic test_reset_mid;
    exp_t e;
    int   seen_done = 0;
    kick(2, 3);
    for (int i = 0; i < 4; i++) begin
      e = q.pop_front();
      compared++;
      if (num !== e.num || busy !== e.busy || pat_cnt !== e.pc) begin
        mismatched++;
        $display("FAIL rstmid pre cyc%0d: num=%0d busy=%0b pat_cnt=%0d, want %0d/%0b/%0d",
                 i, num, busy, pat_cnt, e.num, e.busy, e.pc);
      end
      @(negedge clk);
    end
    q.delete();
    #1 rst_n = 1'b0;
    #1;
    compared++;
    if (num !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || pat_cnt !== 4'd0) begin
      mismatched++;
      $display("FAIL rstmid async: num=%0d busy=%0b done=%0b pat_cnt=%0d, want 0/0/0/0",
               num, busy, done, pat_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    compared++;
    if (seen_done != 0) begin
      mismatched++;
      $display("FAIL rstmid quiet: done/busy seen %0d cycles, want 0", seen_done);
    end
    test_burst("rstmid_after", 2, 1);
  endtask

`ifdef SEQ_GEN_ABORT_EN
  task automatic test_abort;
    exp_t e;
    kick(3, 0);
    // E1 E2 E3 GAP E1 -> next negedge is E2 of pattern 2
    for (int i = 0; i < 5; i++) begin
      e = q.pop_front();
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    q.delete();
    compared++;
    if (num !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || pat_cnt !== 4'd1) begin
      mismatched++;
      $display("FAIL abort: num=%0d busy=%0b done=%0b pat_cnt=%0d, want 0/0/0/1",
               num, busy, done, pat_cnt);
    end
    // abort together with start in IDLE: start wins
    abort = 1'b1;
    kick(1, 0);
    abort = 1'b0;
    compared++;
    if (num !== 2'd1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_idle: num=%0d busy=%0b, want 1/1", num, busy);
    end
    q.delete();
    repeat (4) @(negedge clk);
  endtask
`endif

  initial begin
`ifdef SEQ_GEN_ABORT_EN
    abort = 1'b0;
`endif
    test_reset;
    test_burst("single", 1, 0);
    test_burst("hold", 2, 2);
    test_burst("zero", 0, 2);
    test_restart;
    test_back_to_back;
    test_reset_mid;
`ifdef SEQ_GEN_ABORT_EN
    test_abort;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared=%0d", compared);
    $fatal(1);
  end

endmodule
